intr_context_seq: RTL and testbench

INTR_CONTEXT_SEQ -- requirements
Module: intr_context_seq

---
 rtl/intr_context_seq.sv | 182 ++++++++++++++++++
 tb/tb_intr_context_seq.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intr_context_seq.sv
// Interrupt entry / RTI context sequencer.
// Pushes PC and CCR, fetches the vector, and pops them back on RTI.
module intr_context_seq #(
    parameter logic [31:0] VECTOR_ADDR = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        irq,
    input  logic        rti_req,
    input  logic        boundary,
    input  logic [31:0] pc_in,
    input  logic [3:0]  ccr_in,
    input  logic [31:0] sp_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        sp_dec,
    output logic        sp_inc,
    output logic        stall,
    output logic        pc_load,
    output logic [31:0] pc_load_val,
    output logic        ccr_load_from_stack,
    output logic [3:0]  ccr_stack_flags,
    output logic        int_ack,
    output logic        int_active
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH_PC,
        S_PUSH_CCR,
        S_FETCH_VEC,
        S_POP_CCR,
        S_POP_PC,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic        int_active_q, int_active_d;
    logic        rti_q, rti_d;
    logic        first_q, first_d;
    logic [31:0] pc_lat_q, pc_lat_d;
    logic [3:0]  ccr_lat_q, ccr_lat_d;
    logic [31:0] target_q, target_d;
    logic [3:0]  flags_q, flags_d;
    logic [31:0] sp_lat_q, sp_lat_d;
    logic [31:0] sp_cur;

    // SP is taken live in a state's first cycle, then held for its wait cycles
    assign sp_cur   = first_q ? sp_in : sp_lat_q;
    assign sp_lat_d = sp_cur;
    assign first_d  = (state_d != state_q);

    assign int_active      = int_active_q;
    assign ccr_stack_flags = flags_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            int_active_q <= 1'b0;
            rti_q        <= 1'b0;
            first_q      <= 1'b0;
            pc_lat_q     <= 32'h0;
            ccr_lat_q    <= 4'h0;
            target_q     <= 32'h0;
            flags_q      <= 4'h0;
            sp_lat_q     <= 32'h0;
        end else begin
            state_q      <= state_d;
            int_active_q <= int_active_d;
            rti_q        <= rti_d;
            first_q      <= first_d;
            pc_lat_q     <= pc_lat_d;
            ccr_lat_q    <= ccr_lat_d;
            target_q     <= target_d;
            flags_q      <= flags_d;
            sp_lat_q     <= sp_lat_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        int_active_d        = int_active_q;
        rti_d               = rti_q;
        pc_lat_d            = pc_lat_q;
        ccr_lat_d           = ccr_lat_q;
        target_d            = target_q;
        flags_d             = flags_q;
        mem_req             = 1'b0;
        mem_we              = 1'b0;
        mem_addr            = 32'h0;
        mem_wdata           = 32'h0;
        sp_dec              = 1'b0;
        sp_inc              = 1'b0;
        stall               = 1'b1;
        pc_load             = 1'b0;
        pc_load_val         = 32'h0;
        ccr_load_from_stack = 1'b0;
        int_ack             = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                stall = 1'b0;
                // RTI wins; a pending irq waits for a later boundary
                if (rti_req) begin
                    state_d = S_POP_CCR;
                    rti_d   = 1'b1;
                end else if (irq && boundary && !int_active_q) begin
                    state_d      = S_PUSH_PC;
                    rti_d        = 1'b0;
                    int_active_d = 1'b1;
                    pc_lat_d     = pc_in;
                    ccr_lat_d    = ccr_in;
                end
            end
            S_PUSH_PC: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = sp_cur;
                mem_wdata = pc_lat_q;
                if (mem_ack) begin
                    sp_dec  = 1'b1;
                    state_d = S_PUSH_CCR;
                end
            end
            S_PUSH_CCR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = sp_cur;
                mem_wdata = {28'h0, ccr_lat_q};
                if (mem_ack) begin
                    sp_dec  = 1'b1;
                    state_d = S_FETCH_VEC;
                end
            end
            S_FETCH_VEC: begin
                mem_req  = 1'b1;
                mem_addr = VECTOR_ADDR;
                if (mem_ack) begin
                    target_d = mem_rdata;
                    state_d  = S_DONE;
                end
            end
            S_POP_CCR: begin
                mem_req  = 1'b1;
                mem_addr = sp_cur + 32'h1;
                if (mem_ack) begin
                    sp_inc  = 1'b1;
                    flags_d = mem_rdata[3:0];
                    state_d = S_POP_PC;
                end
            end
            S_POP_PC: begin
                mem_req  = 1'b1;
                mem_addr = sp_cur + 32'h1;
                if (mem_ack) begin
                    sp_inc   = 1'b1;
                    target_d = mem_rdata;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                pc_load     = 1'b1;
                pc_load_val = target_q;
                if (rti_q) begin
                    ccr_load_from_stack = 1'b1;
                    int_active_d        = 1'b0;
                end else begin
                    int_ack = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_intr_context_seq.sv
// Directed bench for intr_context_seq with a wait-state memory
// model and an SP register model.
module tb_intr_context_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        irq = 1'b0;
    logic        rti_req = 1'b0;
    logic        boundary = 1'b1;
    logic [31:0] pc_in = 32'h0;
    logic [3:0]  ccr_in = 4'h0;
    logic [31:0] sp_in = 32'h0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;
    logic        sp_dec, sp_inc, stall, pc_load;
    logic [31:0] pc_load_val;
    logic        ccr_load_from_stack;
    logic [3:0]  ccr_stack_flags;
    logic        int_ack, int_active;

    intr_context_seq #(.VECTOR_ADDR(32'h0000_0001)) dut (
        .clk(clk), .rst_n(rst_n), .irq(irq), .rti_req(rti_req),
        .boundary(boundary), .pc_in(pc_in), .ccr_in(ccr_in),
        .sp_in(sp_in), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .sp_dec(sp_dec),
        .sp_inc(sp_inc), .stall(stall), .pc_load(pc_load),
        .pc_load_val(pc_load_val),
        .ccr_load_from_stack(ccr_load_from_stack),
        .ccr_stack_flags(ccr_stack_flags), .int_ack(int_ack),
        .int_active(int_active)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // SP register model
    logic        sp_wr = 1'b0;
    logic [31:0] sp_wr_val = 32'h0;
    always @(posedge clk) begin
        if (sp_wr) sp_in <= sp_wr_val;
        else if (sp_dec) sp_in <= sp_in - 32'h1;
        else if (sp_inc) sp_in <= sp_in + 32'h1;
    end

    task automatic set_sp(input logic [31:0] v);
        sp_wr = 1'b1;
        sp_wr_val = v;
        @(posedge clk);
        #1 sp_wr = 1'b0;
    endtask

    // Memory model: preloaded rom, written ram, configurable waits
    logic [31:0] rom [logic [31:0]];
    logic [31:0] ram [logic [31:0]];
    int waits = 0;
    int wcnt = 0;

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        if (rom.exists(a)) return rom[a];
        return 32'h0;
    endfunction

    always @(negedge clk) begin
        if (mem_req) begin
            if (wcnt == waits) begin
                mem_ack = 1'b1;
                wcnt = 0;
                if (mem_we) ram[mem_addr] = mem_wdata;
                else mem_rdata = rd(mem_addr);
            end else begin
                mem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ack = 1'b0;
            wcnt = 0;
        end
    end

    // Monitor: monotonic event counters and transaction logs
    int cyc = 0, n_stall = 0, n_req = 0, n_spdec = 0, n_spinc = 0;
    int n_ack = 0, n_ccrl = 0, n_pload = 0, n_unstable = 0;
    int last_pload_cyc = 0, last_ack_cyc = 0, last_ccrl_cyc = 0;
    int last_pload_stall = 0;
    logic [31:0] last_pcval = 32'h0;
    logic [3:0]  last_flags = 4'h0;
    logic [31:0] wq_addr[$], wq_data[$], rq_addr[$];
    logic        p_req = 1'b0, p_ack = 1'b0, p_we = 1'b0;
    logic [31:0] p_addr = 32'h0, p_wd = 32'h0;

    always @(negedge clk) begin
        #2;
        cyc++;
        if (stall) n_stall++;
        if (mem_req) n_req++;
        if (mem_req && p_req && !p_ack &&
            (mem_addr != p_addr || mem_we != p_we || mem_wdata != p_wd))
            n_unstable++;
        p_req = mem_req; p_ack = mem_ack; p_we = mem_we;
        p_addr = mem_addr; p_wd = mem_wdata;
        if (sp_dec) n_spdec++;
        if (sp_inc) n_spinc++;
        if (mem_req && mem_ack) begin
            if (mem_we) begin
                wq_addr.push_back(mem_addr);
                wq_data.push_back(mem_wdata);
            end else begin
                rq_addr.push_back(mem_addr);
            end
        end
        if (pc_load) begin
            n_pload++;
            last_pcval = pc_load_val;
            last_pload_cyc = cyc;
            last_pload_stall = n_stall;
        end
        if (int_ack) begin
            n_ack++;
            last_ack_cyc = cyc;
        end
        if (ccr_load_from_stack) begin
            n_ccrl++;
            last_ccrl_cyc = cyc;
            last_flags = ccr_stack_flags;
        end
    end

    int b_stall, b_req, b_spdec, b_spinc, b_ack, b_ccrl, b_pload;
    int b_unst, bw, br;

    task automatic snap();
        b_stall = n_stall; b_req = n_req; b_spdec = n_spdec;
        b_spinc = n_spinc; b_ack = n_ack; b_ccrl = n_ccrl;
        b_pload = n_pload; b_unst = n_unstable;
        bw = wq_addr.size(); br = rq_addr.size();
    endtask

    function automatic logic [31:0] wa(input int i);
        return (wq_addr.size() > bw + i) ? wq_addr[bw + i] : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] wd(input int i);
        return (wq_data.size() > bw + i) ? wq_data[bw + i] : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] ra(input int i);
        return (rq_addr.size() > br + i) ? rq_addr[br + i] : 32'hDEAD_BEEF;
    endfunction

    task automatic wait_pload(input int maxc);
        int base;
        int k;
        base = n_pload;
        k = 0;
        while (n_pload == base && k < maxc) begin
            @(posedge clk);
            k++;
        end
        chk("pc_load_seen", n_pload, base + 1);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int c1;
    int k;

    initial begin
        rom[32'h1] = 32'h300;
        rom[32'h800] = 32'hA;
        rom[32'h801] = 32'h444;
        rom[32'h0] = 32'h9;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_active", int_active, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_pcval", pc_load_val, 0);
        chk("rst_flags", ccr_stack_flags, 0);
        rst_n = 1'b1;
        set_sp(32'h7FF);

        // Zero-wait entry
        pc_in = 32'h120; ccr_in = 4'b0101;
        snap();
        irq = 1'b1;
        wait_pload(20);
        irq = 1'b0;
        chk("ent_nwr", wq_addr.size() - bw, 2);
        chk("ent_wa0", wa(0), 32'h7FF);
        chk("ent_wd0", wd(0), 32'h120);
        chk("ent_wa1", wa(1), 32'h7FE);
        chk("ent_wd1", wd(1), 32'h5);
        chk("ent_ra0", ra(0), 32'h1);
        chk("ent_spdec", n_spdec - b_spdec, 2);
        chk("ent_pcval", last_pcval, 32'h300);
        chk("ent_ack", n_ack - b_ack, 1);
        chk("ent_ack_cyc", last_ack_cyc, last_pload_cyc);
        chk("ent_pl_idx", last_pload_stall - b_stall, 4);
        chk("ent_active", int_active, 1);
        chk("ent_sp", sp_in, 32'h7FD);

        // irq held while active: no traffic
        snap();
        irq = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("mask_req", n_req - b_req, 0);
        chk("mask_stall", n_stall - b_stall, 0);
        irq = 1'b0;

        // RTI
        snap();
        rti_req = 1'b1;
        wait_pload(20);
        rti_req = 1'b0;
        chk("rti_nrd", rq_addr.size() - br, 2);
        chk("rti_ra0", ra(0), 32'h7FE);
        chk("rti_ra1", ra(1), 32'h7FF);
        chk("rti_spinc", n_spinc - b_spinc, 2);
        chk("rti_pcval", last_pcval, 32'h120);
        chk("rti_ccrl", n_ccrl - b_ccrl, 1);
        chk("rti_ccrl_cyc", last_ccrl_cyc, last_pload_cyc);
        chk("rti_flags", last_flags, 4'b0101);
        chk("rti_active", int_active, 0);
        chk("rti_cycles", n_stall - b_stall, 3);
        chk("rti_sp", sp_in, 32'h7FF);

        // irq and rti together: RTI first, entry right after
        pc_in = 32'h1AB; ccr_in = 4'h3;
        snap();
        irq = 1'b1; rti_req = 1'b1;
        wait_pload(20);
        rti_req = 1'b0;
        chk("both_ccrl", n_ccrl - b_ccrl, 1);
        chk("both_noack", n_ack - b_ack, 0);
        chk("both_pc1", last_pcval, 32'h444);
        chk("both_ra0", ra(0), 32'h800);
        chk("both_flags", last_flags, 4'hA);
        c1 = last_pload_cyc;
        wait_pload(20);
        irq = 1'b0;
        chk("both_ack", n_ack - b_ack, 1);
        chk("both_pc2", last_pcval, 32'h300);
        chk("both_gap", last_pload_cyc - c1, 5);
        chk("both_wa0", wa(0), 32'h801);
        chk("both_wd0", wd(0), 32'h1AB);
        chk("both_wa1", wa(1), 32'h800);
        chk("both_wd1", wd(1), 32'h3);
        chk("both_sp", sp_in, 32'h7FF);

        // RTI across the top of the address space
        set_sp(32'hFFFF_FFFF);
        snap();
        rti_req = 1'b1;
        wait_pload(20);
        rti_req = 1'b0;
        chk("wrap_ra0", ra(0), 32'h0);
        chk("wrap_ra1", ra(1), 32'h1);
        chk("wrap_pc", last_pcval, 32'h300);
        chk("wrap_flags", last_flags, 4'h9);
        chk("wrap_sp", sp_in, 32'h1);
        chk("wrap_active", int_active, 0);

        // Three wait cycles per ack
        waits = 3;
        set_sp(32'h7FF);
        pc_in = 32'h2468; ccr_in = 4'hC;
        snap();
        irq = 1'b1;
        wait_pload(60);
        irq = 1'b0;
        chk("ws_unstable", n_unstable - b_unst, 0);
        chk("ws_cycles", n_stall - b_stall, 13);
        chk("ws_pl_idx", last_pload_stall - b_stall, 13);
        chk("ws_req_cyc", n_req - b_req, 12);
        chk("ws_wa0", wa(0), 32'h7FF);
        chk("ws_wd0", wd(0), 32'h2468);
        chk("ws_wd1", wd(1), 32'hC);

        // Reset during PUSH_CCR
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rs_clr_active", int_active, 0);
        set_sp(32'h7FF);
        snap();
        irq = 1'b1;
        k = 0;
        while (wq_addr.size() == bw && k < 40) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("rs_in_pushccr", mem_wdata, 32'hC);
        #2 rst_n = 1'b0;
        irq = 1'b0;
        #1;
        chk("rs_active", int_active, 0);
        chk("rs_stall", stall, 0);
        chk("rs_req", mem_req, 0);
        chk("rs_wdata", mem_wdata, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        snap();
        repeat (8) @(posedge clk);
        #1;
        chk("rs_pload", n_pload - b_pload, 0);
        chk("rs_spdec", n_spdec - b_spdec, 0);
        chk("rs_ccrl", n_ccrl - b_ccrl, 0);
        chk("rs_stall_after", n_stall - b_stall, 0);

        // Clean entry after the abort
        waits = 0;
        set_sp(32'h500);
        snap();
        irq = 1'b1;
        wait_pload(20);
        irq = 1'b0;
        chk("new_wa0", wa(0), 32'h500);
        chk("new_wd0", wd(0), 32'h2468);
        chk("new_wa1", wa(1), 32'h4FF);
        chk("new_pc", last_pcval, 32'h300);
        chk("new_ack", n_ack - b_ack, 1);
        chk("new_cycles", n_stall - b_stall, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
